serve_sequencer: RTL and testbench
==================================

// Module: serve_sequencer
// PURPOSE
//  Sequences one rally of a level: countdown after level_rst, ball launch, hit scoring, ball speed-up, miss detection.
//  Sits between level_controller and the ball/paddle datapath.
//  Supplies the per-level score and the miss pulse that level_controller consumes.
//  Drives ball hold/launch and speed to the ball motion logic.
// PARAMETERS
//  COUNT_FRAMES    60  frames per countdown step
//  COUNT_STEPS     3   countdown steps before launch (1..3)
//  BASE_SPEED      2   ball speed at launch for lvl_num 0
//  SPEED_STEP_HITS 3   paddle hits per +1 speed increment (>=1)
//  MAX_SPEED       7   speed saturation value (<=15)
//  MISS_FRAMES     30  frames ball stays frozen after a miss
// PORTS
//  frame_clk        in   1  clock (one edge per video frame)
//  game_rst         in   1  asynchronous, active-high reset
//  level_rst        in   1  from level_controller; holds block in IDLE
//  pause            in   1  from level_controller; freezes counters and event inputs
//  lvl_num          in   8  current level 0..4
//  paddle_hit       in   1  ball contacted player paddle this frame
//  ball_past_paddle in   1  ball crossed paddle plane without contact this frame
//  score            out  8  hits this level, saturating at 255
//  miss             out  1  one-frame pulse on miss
//  ball_hold        out  1  ball frozen at serve position
//  ball_launch      out  1  one-frame launch pulse
//  speed            out  4  ball speed magnitude
//  countdown        out  2  countdown digit shown on screen (0 when not counting)
// BEHAVIOUR
//  Reset (game_rst async): state=IDLE, score=0, miss=0, ball_hold=1, ball_launch=0, speed=BASE_SPEED, countdown=0, all counters 0.
//  States: IDLE, COUNTDOWN, LAUNCH, RALLY, MISS_HOLD. All registered; outputs are decoded from registered state and counters.
//  IDLE: ball_hold=1; score=0; hit_cnt=0. Exit to COUNTDOWN on the first frame_clk edge with level_rst=0 and pause=0.
//    On entering COUNTDOWN: speed <= min(BASE_SPEED+lvl_num[2:0], MAX_SPEED); step=COUNT_STEPS; frame_cnt=0.
//  COUNTDOWN: ball_hold=1; countdown=step.
//    frame_cnt increments per frame while pause=0.
//    At frame_cnt==COUNT_FRAMES-1: frame_cnt<=0; step decrements.
//    At step==1 with that terminal count: go to LAUNCH.
//  LAUNCH: exactly one frame; ball_launch=1, ball_hold=0, countdown=0; then RALLY unconditionally.
//  RALLY: ball_hold=0. paddle_hit and ball_past_paddle are sampled only when pause=0.
//    paddle_hit=1: score+1 (saturating at 255); hit_cnt+1.
//      If hit_cnt+1 reaches SPEED_STEP_HITS: hit_cnt<=0 and speed+1 (saturating at MAX_SPEED).
//    ball_past_paddle=1 with paddle_hit=0: miss=1 for the next frame only; go to MISS_HOLD; score frozen.
//    paddle_hit and ball_past_paddle both 1: counted as a hit; no miss.
//  MISS_HOLD: ball_hold=1; miss=0 after its single frame.
//    Wait MISS_FRAMES frames; the wait is not paused. Then go to IDLE.
//  level_rst=1 in any state: next edge goes to IDLE.
//    Clears score, hit_cnt, countdown, miss, ball_launch; sets ball_hold=1.
//    This takes priority over every other transition, including a same-frame hit or miss.
//  Latency: paddle_hit -> score visible one frame_clk edge later. ball_past_paddle -> miss one edge later.
//  Widths: lvl_num truncated to [2:0] for the speed add. Sum computed in 5 bits before the MAX_SPEED clamp.
// TESTING
//  Reset mid-RALLY with score=4 -> immediately score=0, ball_hold=1, state IDLE, no miss pulse.
//  level_rst 1->0, lvl_num=1, defaults -> countdown 3,2,1 for 60 frames each.
//    Then ball_launch high for exactly frame 181, speed=3.
//  RALLY, 6 paddle_hit pulses, lvl_num=0 -> score=6; speed 2->3 after hit 3 and ->4 after hit 6.
//  paddle_hit and ball_past_paddle in the same frame -> score+1, miss stays 0.
//  ball_past_paddle alone -> miss high exactly one frame, ball_hold=1, IDLE after 30 frames.
//  pause=1 during COUNTDOWN for 10 frames, with hits injected in RALLY while paused
//    -> countdown extended by 10 frames; paused hits ignored.

Source files
------------

// File: rtl/serve_sequencer.sv
// serve_sequencer: runs one rally of a level. Counts down after level_rst,
// launches the ball, scores paddle hits with periodic speed-up, detects a
// miss, freezes the ball for a while, then returns to IDLE.
module serve_sequencer #(
  parameter int COUNT_FRAMES    = 60,
  parameter int COUNT_STEPS     = 3,
  parameter int BASE_SPEED      = 2,
  parameter int SPEED_STEP_HITS = 3,
  parameter int MAX_SPEED       = 7,
  parameter int MISS_FRAMES     = 30
) (
  input  logic       frame_clk,
  input  logic       game_rst,
  input  logic       level_rst,
  input  logic       pause,
  input  logic [7:0] lvl_num,
  input  logic       paddle_hit,
  input  logic       ball_past_paddle,
  output logic [7:0] score,
  output logic       miss,
  output logic       ball_hold,
  output logic       ball_launch,
  output logic [3:0] speed,
  output logic [1:0] countdown
);

  // One frame counter serves both the countdown steps and the miss freeze.
  localparam int CNT_MAX = (COUNT_FRAMES > MISS_FRAMES) ? COUNT_FRAMES : MISS_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(SPEED_STEP_HITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_LAUNCH,
    S_RALLY,
    S_MISS_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      score_q, score_d;
  logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [3:0]      speed_q, speed_d;
  logic [1:0]      step_q, step_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            miss_q, miss_d;

  logic [4:0]      speed_sum;
  logic [3:0]      launch_speed;
  logic            unused_lvl_bits;

  // Only the low three level bits feed the launch speed.
  assign unused_lvl_bits = ^lvl_num[7:3];

  // Launch speed: 5-bit sum of base and level, clamped to the ceiling.
  always_comb begin
    speed_sum    = 5'(BASE_SPEED) + {2'b00, lvl_num[2:0]};
    launch_speed = (speed_sum > 5'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_sum[3:0];
  end

  // State and datapath registers.
  always_ff @(posedge frame_clk or posedge game_rst) begin
    if (game_rst) begin
      state_q     <= S_IDLE;
      score_q     <= 8'd0;
      hit_cnt_q   <= '0;
      speed_q     <= 4'(BASE_SPEED);
      step_q      <= 2'd0;
      frame_cnt_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hit_cnt_q   <= hit_cnt_d;
      speed_q     <= speed_d;
      step_q      <= step_d;
      frame_cnt_q <= frame_cnt_d;
      miss_q      <= miss_d;
    end
  end

  // Next-state logic; level_rst overrides every other transition.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hit_cnt_d   = hit_cnt_q;
    speed_d     = speed_q;
    step_d      = step_q;
    frame_cnt_d = frame_cnt_q;
    miss_d      = 1'b0;

    if (level_rst) begin
      state_d     = S_IDLE;
      score_d     = 8'd0;
      hit_cnt_d   = '0;
      step_d      = 2'd0;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          score_d   = 8'd0;
          hit_cnt_d = '0;
          if (!pause) begin
            state_d     = S_COUNTDOWN;
            speed_d     = launch_speed;
            step_d      = 2'(COUNT_STEPS);
            frame_cnt_d = '0;
          end
        end
        S_COUNTDOWN: begin
          if (!pause) begin
            if (frame_cnt_q == CW'(COUNT_FRAMES - 1)) begin
              frame_cnt_d = '0;
              step_d      = step_q - 2'd1;
              if (step_q == 2'd1) begin
                state_d = S_LAUNCH;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          state_d = S_RALLY;
        end
        S_RALLY: begin
          if (!pause) begin
            if (paddle_hit) begin
              if (score_q != 8'hFF) begin
                score_d = score_q + 8'd1;
              end
              if (hit_cnt_q == HW'(SPEED_STEP_HITS - 1)) begin
                hit_cnt_d = '0;
                if (speed_q < 4'(MAX_SPEED)) begin
                  speed_d = speed_q + 4'd1;
                end
              end else begin
                hit_cnt_d = hit_cnt_q + 1'b1;
              end
            end else if (ball_past_paddle) begin
              miss_d      = 1'b1;
              state_d     = S_MISS_HOLD;
              frame_cnt_d = '0;
            end
          end
        end
        S_MISS_HOLD: begin
          if (frame_cnt_q == CW'(MISS_FRAMES - 1)) begin
            state_d     = S_IDLE;
            frame_cnt_d = '0;
            score_d     = 8'd0;
            hit_cnt_d   = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    score       = score_q;
    miss        = miss_q;
    speed       = speed_q;
    ball_launch = (state_q == S_LAUNCH);
    ball_hold   = (state_q != S_LAUNCH) && (state_q != S_RALLY);
    countdown   = (state_q == S_COUNTDOWN) ? step_q : 2'd0;
  end

endmodule

// File: tb/tb_serve_sequencer.sv
// Directed bench for serve_sequencer: countdown timing, launch, hit scoring
// and speed-up, pause behaviour, miss pulse/freeze and async reset.
module tb_serve_sequencer;

  logic       frame_clk = 1'b0;
  logic       game_rst = 1'b0;
  logic       level_rst = 1'b1;
  logic       pause = 1'b0;
  logic [7:0] lvl_num = 8'd1;
  logic       paddle_hit = 1'b0;
  logic       ball_past_paddle = 1'b0;
  logic [7:0] score;
  logic       miss;
  logic       ball_hold;
  logic       ball_launch;
  logic [3:0] speed;
  logic [1:0] countdown;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    score;
    int    miss;
    int    speed;
    int    hold;
  } exp_t;

  exp_t sb[$];

  serve_sequencer dut (
    .frame_clk       (frame_clk),
    .game_rst        (game_rst),
    .level_rst       (level_rst),
    .pause           (pause),
    .lvl_num         (lvl_num),
    .paddle_hit      (paddle_hit),
    .ball_past_paddle(ball_past_paddle),
    .score           (score),
    .miss            (miss),
    .ball_hold       (ball_hold),
    .ball_launch     (ball_launch),
    .speed           (speed),
    .countdown       (countdown)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Drive one event frame, queue its expected result, compare after the edge.
  task automatic drive(input string tag, input logic hit, input logic past,
                       input int es, input int em, input int esp, input int eh);
    exp_t e;
    paddle_hit       = hit;
    ball_past_paddle = past;
    e = '{tag, es, em, esp, eh};
    sb.push_back(e);
    tick();
    paddle_hit       = 1'b0;
    ball_past_paddle = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_score"}, int'(score), e.score);
    chk({e.tag, "_miss"}, int'(miss), e.miss);
    chk({e.tag, "_speed"}, int'(speed), e.speed);
    chk({e.tag, "_hold"}, int'(ball_hold), e.hold);
    $display("txn %s: score=%0d miss=%0d speed=%0d hold=%0d", e.tag, score, miss, speed, ball_hold);
  endtask

  initial begin
    int cd_exp;

    // Reset state
    #1 game_rst = 1'b1;
    #1;
    chk("rst_score", int'(score), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_hold", int'(ball_hold), 1);
    chk("rst_launch", int'(ball_launch), 0);
    chk("rst_speed", int'(speed), 2);
    chk("rst_countdown", int'(countdown), 0);
    tick();
    tick();
    game_rst = 1'b0;
    tick();

    // Level 1 countdown: 3,2,1 for 60 frames each, launch at frame 181
    level_rst = 1'b0;
    for (int f = 1; f <= 180; f++) begin
      tick();
      cd_exp = 3 - (f - 1) / 60;
      chk($sformatf("a_cd_f%0d", f), int'(countdown), cd_exp);
      chk($sformatf("a_hold_f%0d", f), int'(ball_hold), 1);
      chk($sformatf("a_launch_f%0d", f), int'(ball_launch), 0);
    end
    tick();
    chk("a_launch_181", int'(ball_launch), 1);
    chk("a_hold_181", int'(ball_hold), 0);
    chk("a_cd_181", int'(countdown), 0);
    chk("a_speed_181", int'(speed), 3);
    tick();
    chk("a_launch_182", int'(ball_launch), 0);
    chk("a_hold_182", int'(ball_hold), 0);

    // Rally at level 1: simultaneous hit+past is a hit, speed-up on 3rd hit
    drive("a_both", 1'b1, 1'b1, 1, 0, 3, 0);
    drive("a_hit2", 1'b1, 1'b0, 2, 0, 3, 0);
    drive("a_hit3", 1'b1, 1'b0, 3, 0, 4, 0);
    drive("a_hit4", 1'b1, 1'b0, 4, 0, 4, 0);
    pause = 1'b1;
    drive("a_phit", 1'b1, 1'b0, 4, 0, 4, 0);
    drive("a_ppast", 1'b0, 1'b1, 4, 0, 4, 0);
    pause = 1'b0;

    // Async reset mid-rally with score 4
    #3 game_rst = 1'b1;
    #1;
    chk("grst_score", int'(score), 0);
    chk("grst_hold", int'(ball_hold), 1);
    chk("grst_miss", int'(miss), 0);
    chk("grst_cd", int'(countdown), 0);
    chk("grst_speed", int'(speed), 2);
    level_rst = 1'b1;
    tick();
    game_rst = 1'b0;
    tick();
    chk("grst_miss_after", int'(miss), 0);
    chk("grst_hold_after", int'(ball_hold), 1);

    // Level 0 countdown with 10 paused frames: launch moves to frame 191
    lvl_num   = 8'd0;
    level_rst = 1'b0;
    for (int f = 1; f <= 191; f++) begin
      if (f == 21) pause = 1'b1;
      if (f == 31) pause = 1'b0;
      tick();
      cd_exp = (f <= 70) ? 3 : (f <= 130) ? 2 : (f <= 190) ? 1 : 0;
      chk($sformatf("b_cd_f%0d", f), int'(countdown), cd_exp);
      chk($sformatf("b_launch_f%0d", f), int'(ball_launch), (f == 191) ? 1 : 0);
      chk($sformatf("b_hold_f%0d", f), int'(ball_hold), (f == 191) ? 0 : 1);
    end
    chk("b_speed_launch", int'(speed), 2);
    tick();

    // Six hits at level 0 with paused hits injected
    drive("b_hit1", 1'b1, 1'b0, 1, 0, 2, 0);
    pause = 1'b1;
    drive("b_phit", 1'b1, 1'b0, 1, 0, 2, 0);
    drive("b_ppast", 1'b0, 1'b1, 1, 0, 2, 0);
    pause = 1'b0;
    drive("b_hit2", 1'b1, 1'b0, 2, 0, 2, 0);
    drive("b_hit3", 1'b1, 1'b0, 3, 0, 3, 0);
    pause = 1'b1;
    drive("b_phit2", 1'b1, 1'b0, 3, 0, 3, 0);
    pause = 1'b0;
    drive("b_hit4", 1'b1, 1'b0, 4, 0, 3, 0);
    drive("b_hit5", 1'b1, 1'b0, 5, 0, 3, 0);
    drive("b_hit6", 1'b1, 1'b0, 6, 0, 4, 0);

    // Miss: one-frame pulse, 30-frame freeze, then IDLE, then restart
    drive("b_miss", 1'b0, 1'b1, 6, 1, 4, 1);
    for (int k = 1; k <= 29; k++) begin
      tick();
      chk($sformatf("mh_miss_k%0d", k), int'(miss), 0);
      chk($sformatf("mh_hold_k%0d", k), int'(ball_hold), 1);
      chk($sformatf("mh_score_k%0d", k), int'(score), 6);
      chk($sformatf("mh_cd_k%0d", k), int'(countdown), 0);
    end
    tick();
    chk("idle_score", int'(score), 0);
    chk("idle_hold", int'(ball_hold), 1);
    chk("idle_cd", int'(countdown), 0);
    chk("idle_miss", int'(miss), 0);
    tick();
    chk("restart_cd", int'(countdown), 3);
    chk("restart_speed", int'(speed), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
